// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flop-based FIFO family.
package fifo_pkg;

  localparam int FIFO_DEPTH_DEF = 16;
  localparam int FIFO_BITS_DEF  = 16;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_flops_mem.sv
// DEPTH x BITS flop storage: one synchronous write port, one asynchronous read port.
module fifo_flops_mem #(
  parameter int DEPTH = 16,
  parameter int BITS  = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [BITS-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [BITS-1:0] rdata
);

  logic [BITS-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; only pointers define valid contents.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_flops_thr.sv
// Flop FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through Dout; otherwise Dout is registered on pop.
module fifo_flops_thr
  import fifo_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int BITS   = FIFO_BITS_DEF,
  parameter int AF_THR = 14,
  parameter int AE_THR = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BITS-1:0]         Din,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    err_clr,
  output logic [BITS-1:0]         Dout,
  output logic                    full,
  output logic                    pndng,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  err_flags_t      err_q, err_d;
  logic            push_ok, pop_ok;
  logic [BITS-1:0] rdata;

  // Explicit wrap so non-power-of-two depths never address past DEPTH-1.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  fifo_flops_mem #(.DEPTH(DEPTH), .BITS(BITS), .AW(PW)) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (Din),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // Status decodes depend on the count register only, never on push/pop.
  assign full         = (count_q == CW'(DEPTH));
  assign pndng        = (count_q != '0);
  assign almost_full  = (count_q >= CW'(AF_THR));
  assign almost_empty = (count_q <= CW'(AE_THR));
  assign count        = count_q;
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

  always_comb begin
    pop_ok   = pop && pndng;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    // Clear first so a same-cycle error wins over err_clr.
    err_d = err_q;
    if (err_clr)                 err_d = '0;
    if (push && full && !pop_ok) err_d.overflow  = 1'b1;
    if (pop && !pndng)           err_d.underflow = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

`ifdef FIFO_FWFT_EN
  assign Dout = rdata;
`else
  logic [BITS-1:0] dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         dout_q <= '0;
    else if (pop_ok) dout_q <= rdata;
  end

  assign Dout = dout_q;
`endif

endmodule

// File: tb/tb_fifo_flops_thr.sv
// Bench for fifo_flops_thr: DEPTH=16 and DEPTH=5 instances checked against a queue model.
module tb_fifo_flops_thr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        push_v [2];
  logic        pop_v  [2];
  logic        clr_v  [2];
  logic [15:0] din_v  [2];
  logic [15:0] dout_v [2];
  logic        full_v [2];
  logic        pnd_v  [2];
  logic        af_v   [2];
  logic        ae_v   [2];
  logic        ovf_v  [2];
  logic        udf_v  [2];
  logic [4:0]  cnt_a;
  logic [2:0]  cnt_b;

  fifo_flops_thr #(.DEPTH(16), .BITS(16), .AF_THR(14), .AE_THR(2)) dut_a (
    .clk(clk), .rst(rst), .Din(din_v[0]), .push(push_v[0]), .pop(pop_v[0]),
    .err_clr(clr_v[0]), .Dout(dout_v[0]), .full(full_v[0]), .pndng(pnd_v[0]),
    .count(cnt_a), .almost_full(af_v[0]), .almost_empty(ae_v[0]),
    .overflow(ovf_v[0]), .underflow(udf_v[0])
  );

  fifo_flops_thr #(.DEPTH(5), .BITS(16), .AF_THR(4), .AE_THR(1)) dut_b (
    .clk(clk), .rst(rst), .Din(din_v[1]), .push(push_v[1]), .pop(pop_v[1]),
    .err_clr(clr_v[1]), .Dout(dout_v[1]), .full(full_v[1]), .pndng(pnd_v[1]),
    .count(cnt_b), .almost_full(af_v[1]), .almost_empty(ae_v[1]),
    .overflow(ovf_v[1]), .underflow(udf_v[1])
  );

  int errs = 0;
  int checks = 0;

  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic        m_ovf  [2];
  logic        m_udf  [2];
  logic [15:0] m_dout [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int cap(input int u);     return (u == 0) ? 16 : 5; endfunction
  function automatic int af_thr(input int u);  return (u == 0) ? 14 : 4; endfunction
  function automatic int ae_thr(input int u);  return (u == 0) ? 2 : 1;  endfunction
  function automatic int msize(input int u);   return (u == 0) ? q0.size() : q1.size(); endfunction
  function automatic logic [15:0] mfront(input int u); return (u == 0) ? q0[0] : q1[0]; endfunction
  function automatic logic [31:0] cnt_obs(input int u); return (u == 0) ? 32'(cnt_a) : 32'(cnt_b); endfunction

  task automatic model_clear();
    q0.delete();
    q1.delete();
    for (int u = 0; u < 2; u++) begin
      m_ovf[u] = 1'b0; m_udf[u] = 1'b0; m_dout[u] = '0;
    end
  endtask

  task automatic check_all(input int u, input string tag);
    int sz;
    sz = msize(u);
    check_eq({tag, ".count"}, cnt_obs(u), 32'(sz));
    check_eq({tag, ".full"}, 32'(full_v[u]), 32'(sz == cap(u)));
    check_eq({tag, ".pndng"}, 32'(pnd_v[u]), 32'(sz != 0));
    check_eq({tag, ".afull"}, 32'(af_v[u]), 32'(sz >= af_thr(u)));
    check_eq({tag, ".aempty"}, 32'(ae_v[u]), 32'(sz <= ae_thr(u)));
    check_eq({tag, ".ovf"}, 32'(ovf_v[u]), 32'(m_ovf[u]));
    check_eq({tag, ".udf"}, 32'(udf_v[u]), 32'(m_udf[u]));
`ifdef FIFO_FWFT_EN
    if (sz > 0) check_eq({tag, ".dout"}, 32'(dout_v[u]), 32'(mfront(u)));
`else
    check_eq({tag, ".dout"}, 32'(dout_v[u]), 32'(m_dout[u]));
`endif
  endtask

  // One clock of traffic on unit u; the model applies the FIFO rules to the pre-edge occupancy.
  task automatic step(input int u, input bit ps, input bit pp, input logic [15:0] d,
                      input bit c, input string tag);
    int sz;
    bit pop_ok, push_ok;
    sz = msize(u);
    push_v[u] = ps; pop_v[u] = pp; din_v[u] = d; clr_v[u] = c;
    @(posedge clk); #1;
    pop_ok  = pp && (sz > 0);
    push_ok = ps && ((sz < cap(u)) || pop_ok);
    if (c) begin m_ovf[u] = 1'b0; m_udf[u] = 1'b0; end
    if (ps && (sz == cap(u)) && !pop_ok) m_ovf[u] = 1'b1;
    if (pp && (sz == 0)) m_udf[u] = 1'b1;
    if (pop_ok) m_dout[u] = (u == 0) ? q0.pop_front() : q1.pop_front();
    if (push_ok) begin
      if (u == 0) q0.push_back(d); else q1.push_back(d);
    end
    push_v[u] = 1'b0; pop_v[u] = 1'b0; clr_v[u] = 1'b0;
    check_all(u, tag);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      push_v[u] = 1'b1; pop_v[u] = 1'b0; clr_v[u] = 1'b0; din_v[u] = 16'hAAAA;
    end
    model_clear();

    // Test 1: reset held with push asserted
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_all(0, "rst_a");
    check_all(1, "rst_b");
    push_v[0] = 1'b0; push_v[1] = 1'b0;
    rst = 1'b0;
    step(0, 0, 0, 16'h0, 0, "post_rst");

    // Test 2: fill then drain in order
    for (int i = 0; i < 16; i++) step(0, 1, 0, 16'(i), 0, "fill");
    for (int i = 0; i < 16; i++) step(0, 0, 1, 16'h0, 0, "drain");

    // Test 3: overflow drops the push and leaves contents untouched
    for (int i = 0; i < 16; i++) step(0, 1, 0, 16'(i), 0, "fill3");
    step(0, 1, 0, 16'h00FF, 0, "ovf_push");
    check_eq("t3_ovf_set", 32'(ovf_v[0]), 32'd1);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 16'h0, 0, "drain3");
    step(0, 0, 0, 16'h0, 1, "ovf_clr");
    check_eq("t3_ovf_clr", 32'(ovf_v[0]), 32'd0);

    // Test 4: push+pop while full
    for (int i = 0; i < 16; i++) step(0, 1, 0, 16'(i), 0, "fill4");
    for (int i = 0; i < 4; i++) step(0, 1, 1, 16'(100 + i), 0, "pp_full");
    check_eq("t4_full", 32'(full_v[0]), 32'd1);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 16'h0, 0, "drain4");

    // Test 5: push+pop while empty, then clear colliding with a new underflow
    step(0, 1, 1, 16'h1234, 0, "pp_empty");
    check_eq("t5_udf", 32'(udf_v[0]), 32'd1);
    check_eq("t5_cnt", cnt_obs(0), 32'd1);
    step(0, 0, 1, 16'h0, 0, "pop1234");
    step(0, 0, 1, 16'h0, 1, "clr_vs_udf");
    check_eq("t5_udf_wins", 32'(udf_v[0]), 32'd1);
    step(0, 0, 0, 16'h0, 1, "udf_clr");

    // Test 6: DEPTH=5 wrap through three fill/drain rounds plus interleaving
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) step(1, 1, 0, 16'(16'h500 + r * 5 + i), 0, "b_fill");
      for (int i = 0; i < 5; i++) step(1, 0, 1, 16'h0, 0, "b_drain");
    end
    for (int i = 0; i < 15; i++) step(1, 1, (i % 3) != 0, 16'(16'h700 + i), 0, "b_mix");

    // Reset mid-operation takes effect asynchronously
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'(16'h900 + i), 0, "pre_rst");
    rst = 1'b1;
    #1;
    model_clear();
    check_eq("async_rst_cnt", cnt_obs(0), 32'd0);
    check_eq("async_rst_pnd", 32'(pnd_v[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_all(0, "mid_rst_a");
    check_all(1, "mid_rst_b");

    // Randomized traffic on both units
    for (int n = 0; n < 400; n++) begin
      for (int u = 0; u < 2; u++) begin
        step(u, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
             16'($urandom), $urandom_range(0, 99) < 5, (u == 0) ? "rnd_a" : "rnd_b");
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fifo_flops_thr.md
Name: fifo_flops_thr

Overview:
Parametrised successor to the flop-based FIFO. Same push/pop/full/pndng interface, extended with:
- an occupancy count output
- programmable almost-full / almost-empty thresholds
- sticky overflow/underflow error flags with a clear input
- defined simultaneous push/pop behaviour when full
- arbitrary (non-power-of-two) depth

Used as the standard buffering element between producer/consumer agents in the bench and in datapath RTL.

Parameters:
DEPTH, 16, number of entries; any integer >= 2, power of two not required
BITS, 16, data width in bits
AF_THR, 14, almost_full asserts when count >= AF_THR; legal range 1..DEPTH
AE_THR, 2, almost_empty asserts when count <= AE_THR; legal range 0..DEPTH-1

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
Din  in  BITS  write data, sampled when a push is accepted
push  in  1  write request
pop  in  1  read request
err_clr  in  1  clears sticky overflow/underflow
Dout  out  BITS  read data
full  out  1  count == DEPTH
pndng  out  1  count != 0 (data pending)
count  out  CW  occupancy 0..DEPTH; CW = $clog2(DEPTH+1)
almost_full  out  1  count >= AF_THR
almost_empty  out  1  count <= AE_THR
overflow  out  1  sticky: push dropped while full
underflow  out  1  sticky: pop requested while empty

Behaviour:
- Reset (async assert, sync-safe deassert by the user):
  - wr_ptr, rd_ptr, count, Dout, overflow, underflow all go to 0.
  - Hence full=0, pndng=0, almost_empty=1, almost_full=0.
  - Storage array is not reset.
- Reset mid-operation discards all contents immediately, with no partial pop.
- Pointers:
  - Range 0..DEPTH-1.
  - Increment wraps explicitly, i.e. ptr==DEPTH-1 goes to 0. No reliance on natural binary rollover.
- Accept rules, evaluated on the current-cycle state:
  - pop_ok = pop && pndng
  - push_ok = push && (!full || pop_ok)
- Simultaneous push and pop:
  - Full with push+pop: both accepted, count unchanged, wr_ptr and rd_ptr both advance.
  - Empty with push+pop: push accepted, pop ignored, underflow set, count becomes 1.
  - Otherwise: both accepted, count unchanged.
- Count update: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
- Dout (base mode):
  - Registered, 1-cycle pop latency.
  - On pop_ok, Dout <= mem[rd_ptr] at the same edge the pointer advances.
  - Dout holds its value when there is no pop_ok, including a pop while empty.
- Status outputs:
  - full, pndng, almost_full and almost_empty are decoded combinationally from the count register only.
  - They have no combinational path from push/pop.
- Error flags:
  - overflow sets on push && full && !pop_ok.
  - underflow sets on pop && !pndng.
  - Both flags stay set until an err_clr cycle.
  - If err_clr and a new error occur in the same cycle, set wins.
- Data integrity: strict FIFO order. Dropped pushes never modify storage or pointers.

Optional Feature:
Macro FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - Dout = mem[rd_ptr] combinationally; the head is visible while pndng=1.
  - pop_ok advances to the next entry.
  - Dout is don't-care while pndng=0. The bench must not check it then.
- Undefined: registered Dout as in Behaviour.

All other outputs are identical in both modes.

Decomposition:
- Package fifo_pkg:
  - function cnt_w(depth) returning $clog2(depth+1)
  - typedef for the error-flag pair (struct packed {overflow, underflow})
  - localparam defaults for DEPTH/BITS
- Sub-module fifo_flops_mem:
  - DEPTH x BITS flop array
  - Write port: we, waddr, wdata
  - Asynchronous read port: raddr, rdata
- Top-level module holds the pointers, count, flags, the Dout register and the FWFT mux.

Test Plan:
1. Reset held 5 cycles with push=1, Din=0xAAAA -> count=0, pndng=0, full=0, almost_empty=1, Dout=0, nothing stored after release.
2. Push 0..15 (DEPTH=16), then pop 16 -> Dout sequence 0..15 in order. almost_full rises when count reaches 14, full at 16. almost_empty falls when count reaches 3. pndng=0 after the last pop.
3. Fill to 16, then push 0x00FF with no pop -> overflow=1, count stays 16, the following pops return 0..15 with 0x00FF absent. err_clr pulse -> overflow=0.
4. Full FIFO, push=1 + pop=1 for 4 cycles with Din=100..103 -> count stays 16, full stays 1, no overflow. Draining yields 4..15 followed by 100..103.
5. Empty FIFO, push+pop in the same cycle with Din=0x1234 -> underflow=1, count=1. The next pop returns 0x1234. err_clr and a pop on empty in the same cycle -> underflow stays 1.
6. DEPTH=5 build, 3 full fill/drain cycles (15 pushes/pops interleaved, wrapping the pointers) -> exact ordering preserved across the 4->0 pointer wrap. Run with and without FIFO_FWFT_EN; in FWFT mode Dout equals the head value on the same cycle pndng rises.
